prefix_adder_pipe: RTL and testbench

- Parametrised, pipelined parallel-prefix (Kogge-Stone) adder/subtractor for the NTT butterfly datapath.
- Generalises the single gray-cell carry operator, G = g_hi | (p_hi & g_lo), P = p_hi & p_lo, into a full WIDTH-bit prefix tree.
- Pipeline registers sit every PIPE_EVERY prefix levels.
- Valid/ready handshake with back-pressure, so the adder sits between butterfly stages without external stall logic.

---
 rtl/prefix_adder_pipe.sv | 109 ++++++++++
 tb/tb_prefix_adder_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake.
// The operands are conditioned in rank 0, prefix levels run between ranks, and the result is registered at the output.
module prefix_adder_pipe #(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int L       = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam int LATENCY = 1 + (L + PIPE_EVERY - 1) / PIPE_EVERY;

    // Handshake: a beat moves from rank to rank only while advance=1.
    // in_ready = advance = out_ready | ~out_valid. Input beats transfer on in_valid & in_ready.
    // Output beats transfer on out_valid & out_ready. When advance=0 every rank holds.
    logic advance;
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Rank 0 is the conditioned operands. Rank s holds the result of prefix segment s-1.
    logic [WIDTH-1:0] seg_g  [LATENCY];
    logic [WIDTH-1:0] seg_p  [LATENCY];
    logic [WIDTH-1:0] seg_op [LATENCY];
    logic             seg_c0 [LATENCY];
    logic             seg_v  [LATENCY];

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic             c0_in;

    always_comb begin
        b_eff = sub ? ~b : b;
        c0_in = sub ? ~cin : cin;
        p_in  = a ^ b_eff;
        g_in  = a & b_eff;
        // Fold the carry-in into bit 0 so that WIDTH positions need only L levels.
        g_in[0] = g_in[0] | (p_in[0] & c0_in);
    end

    // Prefix levels. A segment restarts from a register rank at every PIPE_EVERY boundary.
    logic [WIDTH-1:0] lvl_g [L];
    logic [WIDTH-1:0] lvl_p [L];
    logic [WIDTH-1:0] run_g;
    logic [WIDTH-1:0] run_p;

    always_comb begin
        run_g = '0;
        run_p = '0;
        for (int k = 0; k < L; k++) begin
            if (k % PIPE_EVERY == 0) begin
                run_g = seg_g[k / PIPE_EVERY];
                run_p = seg_p[k / PIPE_EVERY];
            end
            // Positions below the distance shift in G=0 and P=1, so they pass through unchanged.
            run_g = run_g | (run_p & (run_g << (1 << k)));
            run_p = run_p & ((run_p << (1 << k)) | ~({WIDTH{1'b1}} << (1 << k)));
            lvl_g[k] = run_g;
            lvl_p[k] = run_p;
        end
    end

    // Index of the last prefix level that feeds register rank s (s >= 1).
    function automatic int feed_level(input int s);
        return ((s * PIPE_EVERY < L) ? s * PIPE_EVERY : L) - 1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                seg_v[s]  <= 1'b0;
                seg_g[s]  <= '0;
                seg_p[s]  <= '0;
                seg_op[s] <= '0;
                seg_c0[s] <= 1'b0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (advance) begin
            seg_v[0]  <= in_valid;
            seg_g[0]  <= g_in;
            seg_p[0]  <= p_in;
            seg_op[0] <= p_in;
            seg_c0[0] <= c0_in;
            for (int s = 1; s < LATENCY; s++) begin
                seg_v[s]  <= seg_v[s-1];
                seg_g[s]  <= lvl_g[feed_level(s)];
                seg_p[s]  <= lvl_p[feed_level(s)];
                seg_op[s] <= seg_op[s-1];
                seg_c0[s] <= seg_c0[s-1];
            end
            out_valid <= seg_v[LATENCY-1];
            sum       <= seg_op[LATENCY-1] ^ {seg_g[LATENCY-1][WIDTH-2:0], seg_c0[LATENCY-1]};
            cout      <= seg_g[LATENCY-1][WIDTH-1];
        end
    end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Scoreboarded bench for prefix_adder_pipe: directed cases, back-to-back random beats,
// random back-pressure and a mid-stream asynchronous reset.
`timescale 1ns/1ps
module tb_prefix_adder_pipe;
    localparam int W   = 32;
    localparam int PE  = 2;
    localparam int LAT = 4;  // 1 + ceil(5 prefix levels / 2)

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pushed = 0;
    int popped = 0;
    logic [W:0] exp_q[$];
    bit mon_en = 1'b0;
    bit rand_rdy = 1'b0;
    bit held = 1'b0;
    logic [W-1:0] held_sum;
    logic held_cout;

    prefix_adder_pipe #(.WIDTH(W), .PIPE_EVERY(PE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Reference: plain wide arithmetic; {cout, sum}
    function automatic logic [W:0] model(input logic [W-1:0] xa, xb, input logic xc, xs);
        logic [W:0] r;
        if (!xs) begin
            r = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
        end else begin
            r[W-1:0] = xa - xb - {{(W-1){1'b0}}, xc};
            r[W]     = ({1'b0, xa} >= ({1'b0, xb} + {{W{1'b0}}, xc}));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [W:0] got, want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic chk_int(input string name, input int got, want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst) held = 1'b0;
            total++;
            if (in_ready !== (out_ready | ~out_valid)) begin
                bad++;
                $display("FAIL in_ready got=%b want=%b", in_ready, out_ready | ~out_valid);
            end
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || sum !== held_sum || cout !== held_cout) begin
                    bad++;
                    $display("FAIL stall_hold got=%b/%h/%b want=1/%h/%b",
                             out_valid, sum, cout, held_sum, held_cout);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                held = 1'b0;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat got=%h want=none", {cout, sum});
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    popped++;
                    if ({cout, sum} !== e) begin
                        bad++;
                        $display("FAIL result got=%h want=%h", {cout, sum}, e);
                    end
                end
            end else if (out_valid === 1'b1) begin
                held = 1'b1;
                held_sum = sum;
                held_cout = cout;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic send(input logic [W-1:0] xa, xb, input logic xc, xs, output int waits);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        cin = xc;
        sub = xs;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 1000) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=stalled want=accepted");
        end else begin
            exp_q.push_back(model(xa, xb, xc, xs));
            pushed++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic gen(output logic [W-1:0] xa, xb, output logic xc, xs);
        int sel;
        sel = $urandom_range(0, 7);
        xc = 1'($urandom_range(0, 1));
        xs = 1'($urandom_range(0, 1));
        case (sel)
            0: begin xa = 32'h7FFF_FFFF; xb = 32'h8000_0000; end
            1: begin xa = 32'hFFFF_FFFF; xb = $urandom; end
            2: begin xa = $urandom; xb = ~xa; end
            3: begin xa = $urandom; xb = xa; end
            default: begin xa = $urandom; xb = $urandom; end
        endcase
    endtask

    // Called just after the accepting edge with an empty pipeline.
    task automatic check_latency(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_int(name, n, LAT);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk_int(name, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] xa, xb;
        logic xc, xs;
        int w, stall, c0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {{W{1'b0}}, out_valid}, '0);
        chk("reset_data", {cout, sum}, '0);
        chk("reset_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, w);
        check_latency("lat_add_wrap");
        drain("drain_add_wrap");
        send(32'd5, 32'd7, 1'b0, 1'b1, w);
        check_latency("lat_sub_borrow");
        drain("drain_sub_borrow");
        send(32'd7, 32'd5, 1'b1, 1'b1, w);
        check_latency("lat_sub_cin");
        drain("drain_sub_cin");

        // Back-to-back with full-carry-chain corners leading the stream
        stall = 0;
        c0 = cyc;
        for (int i = 0; i < 1000; i++) begin
            gen(xa, xb, xc, xs);
            if (i == 0) begin xa = 32'h7FFF_FFFF; xb = 32'h8000_0000; xc = 1'b1; xs = 1'b0; end
            if (i == 1) begin xa = 32'h0;         xb = 32'h0;         xc = 1'b1; xs = 1'b1; end
            if (i == 2) begin xa = 32'hFFFF_FFFF; xb = 32'hFFFF_FFFF; xc = 1'b1; xs = 1'b0; end
            if (i == 3) begin xa = 32'hFFFF_FFFF; xb = 32'hFFFF_FFFF; xc = 1'b1; xs = 1'b1; end
            send(xa, xb, xc, xs, w);
            stall += w;
        end
        chk_int("b2b_no_stall", stall, 0);
        chk_int("b2b_cycles", cyc - c0, 1000);
        drain("b2b_drain");
        chk_int("b2b_count", popped, pushed);

        // Random back-pressure with continuous input
        rand_rdy = 1'b1;
        for (int i = 0; i < 500; i++) begin
            gen(xa, xb, xc, xs);
            send(xa, xb, xc, xs, w);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain("stall_drain");
        chk_int("stall_count", popped, pushed);

        // Asynchronous reset with one beat at the output and four in flight
        for (int i = 0; i < 6; i++) begin
            gen(xa, xb, xc, xs);
            send(xa, xb, xc, xs, w);
        end
        chk("pre_reset_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_valid", {{W{1'b0}}, out_valid}, '0);
        chk("async_reset_data", {cout, sum}, '0);
        chk("async_reset_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_reset_idle", {{W{1'b0}}, out_valid}, '0);
        send(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, w);
        check_latency("lat_after_reset");
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
